bcd_time_counter: RTL
=====================

// Module: bcd_time_counter
// PURPOSE
//  - Time-of-day counter for the DE10-Lite clock. Divides the board clock to a 1 Hz tick.
//  - Keeps HH:MM:SS as six BCD digits.
//  - Each digit nibble plus its decimal-point bit feeds one 7-segment LUT stage (HEX0..HEX5) directly downstream.
//  - Also provides hour/minute set, second clear, run/stop and a blinking separator dot.
// PARAMETERS
//  CLK_HZ   50_000_000  iCLK frequency; prescaler period in cycles (>=2)
// PORTS
//  iCLK     in   1  system clock, all logic on rising edge
//  iRST     in   1  synchronous reset, active-high
//  iRUN     in   1  1 = prescaler counts; 0 = time frozen
//  iSET_H   in   1  one-cycle pulse, increment hours (pre-debounced)
//  iSET_M   in   1  one-cycle pulse, increment minutes (pre-debounced)
//  iCLR_SEC in   1  one-cycle pulse, seconds := 00 and prescaler := 0
//  oHEX0    out  4  seconds units (BCD)
//  oHEX1    out  4  seconds tens
//  oHEX2    out  4  minutes units
//  oHEX3    out  4  minutes tens
//  oHEX4    out  4  hours units
//  oHEX5    out  4  hours tens
//  oDOT     out  6  decimal points, active-low (1 = unlit), bit n -> HEXn
//  oTICK    out  1  one-cycle pulse on every 1 Hz tick (registered)
//  oPM      out  1  PM flag (TIME_12H_EN only; else constant 0)
// BEHAVIOUR
//  - Reset values:
//    - all digits 0 (12H mode: oHEX5:oHEX4 = 1:2).
//    - oDOT = 6'b111111, oTICK = 0, oPM = 0, prescaler = 0.
//  - Prescaler, iRUN=1: counts 0..CLK_HZ-1 and wraps.
//    - tick = (cnt == CLK_HZ-1) & iRUN.
//    - iRUN=0 holds cnt; tick stays 0.
//  - All outputs are registered. Digits and oTICK update on the edge after the cycle where tick=1 (1-cycle latency).
//  - Seconds: 00..59 BCD.
//    - Units wrap 9->0 and carry to tens; tens wrap 5->0.
//    - sec_carry = tick at 59.
//  - Minutes: inc_m = sec_carry | iSET_M.
//    - Coincident events give one increment, never two.
//    - 59->00 produces min_carry only when the increment came from sec_carry.
//    - iSET_M never carries into hours.
//  - Hours: inc_h = min_carry | iSET_H, single increment. 24H wraps 23->00.
//  - iCLR_SEC has priority over tick in the same cycle:
//    - seconds := 00, cnt := 0, no sec_carry.
//    - oTICK still pulses if tick was 1.
//    - iSET_H/iSET_M in that cycle still apply.
//  - oDOT[2] and oDOT[4] = 0 while cnt < CLK_HZ/2, else 1. Other bits are always 1.
//    - With iRUN=0 the dots hold their state.
//  - Digits never leave legal BCD ranges. No illegal state is reachable.
//  - iRST mid-count: all state returns to reset values on the next edge. Pending pulses are discarded.
// CONFIGURATION
//  TIME_12H_EN defined:
//    - hours run 12,01..11,12. Increment 12->01.
//    - The 11->12 step via min_carry toggles oPM. iSET_H passing 11->12 also toggles oPM.
//    - Reset: 12:00:00, oPM=0 (AM).
//  TIME_12H_EN undefined:
//    - hours 00..23; oPM tied to 0.
// TESTING (CLK_HZ=4 in sim)
//  1 iRST high 2 cycles -> digits 00:00:00, oDOT=111111, oTICK=0; next cycle oDOT[4]=oDOT[2]=0.
//  2 Preload via iSET to 23:59:59, iRUN=1, one tick -> 00:00:00 one cycle later; oTICK pulses once.
//  3 At 10:59:30, pulse iSET_M -> 10:00:30; hours unchanged.
//  4 At 12:34:59, iSET_M coincident with tick -> 12:35:00 (single increment).
//  5 iCLR_SEC coincident with tick at 00:00:59 -> 00:00:00; minutes stay 00; oTICK=1; cnt restarts at 0.
//  6 iRUN=0 for 20 cycles -> digits, oDOT, cnt frozen, no oTICK; 12H build: 11:59:59 + tick -> 12:00:00, oPM 0->1.

Source files
------------

// File: rtl/bcd_time_counter.sv
// HH:MM:SS time-of-day counter in six BCD digits, driven by a 1 Hz prescaler tick.
// Optional 12-hour display with AM/PM flag when TIME_12H_EN is defined.
module bcd_time_counter #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iRUN,
    input  logic       iSET_H,
    input  logic       iSET_M,
    input  logic       iCLR_SEC,
    output logic [3:0] oHEX0,
    output logic [3:0] oHEX1,
    output logic [3:0] oHEX2,
    output logic [3:0] oHEX3,
    output logic [3:0] oHEX4,
    output logic [3:0] oHEX5,
    output logic [5:0] oDOT,
    output logic       oTICK,
    output logic       oPM
);
    localparam int CW = $clog2(CLK_HZ);
    localparam logic [CW-1:0] CNT_MAX  = CW'(CLK_HZ - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLK_HZ / 2);

`ifdef TIME_12H_EN
    localparam logic [3:0] HR_T_RST = 4'd1;
    localparam logic [3:0] HR_U_RST = 4'd2;
`else
    localparam logic [3:0] HR_T_RST = 4'd0;
    localparam logic [3:0] HR_U_RST = 4'd0;
`endif

    logic [CW-1:0] cnt;
    logic [3:0]    secU, secT, minU, minT, hrU, hrT;
    logic          tickReg;
    logic          dotLit;
    logic          tick, secCarry, minCarry, incM, incH;

    // A clear in the same cycle as the 59->00 tick swallows the minute carry.
    always_comb begin
        tick     = iRUN && (cnt == CNT_MAX);
        secCarry = tick && !iCLR_SEC && (secT == 4'd5) && (secU == 4'd9);
        minCarry = secCarry && (minT == 4'd5) && (minU == 4'd9);
        incM     = secCarry || iSET_M;
        incH     = minCarry || iSET_H;
    end

`ifdef TIME_12H_EN
    logic pm;
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            pm <= 1'b0;
        end else if (incH && (hrT == 4'd1) && (hrU == 4'd1)) begin
            pm <= ~pm;
        end
    end
    assign oPM = pm;
`else
    assign oPM = 1'b0;
`endif

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            cnt     <= '0;
            tickReg <= 1'b0;
            dotLit  <= 1'b0;
            secU    <= 4'd0;
            secT    <= 4'd0;
            minU    <= 4'd0;
            minT    <= 4'd0;
            hrU     <= HR_U_RST;
            hrT     <= HR_T_RST;
        end else begin
            tickReg <= tick;
            dotLit  <= (cnt < CNT_HALF);

            if (iCLR_SEC) begin
                cnt <= '0;
            end else if (iRUN) begin
                cnt <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
            end

            if (iCLR_SEC) begin
                secU <= 4'd0;
                secT <= 4'd0;
            end else if (tick) begin
                if (secU == 4'd9) begin
                    secU <= 4'd0;
                    secT <= (secT == 4'd5) ? 4'd0 : secT + 4'd1;
                end else begin
                    secU <= secU + 4'd1;
                end
            end

            if (incM) begin
                if (minU == 4'd9) begin
                    minU <= 4'd0;
                    minT <= (minT == 4'd5) ? 4'd0 : minT + 4'd1;
                end else begin
                    minU <= minU + 4'd1;
                end
            end

            if (incH) begin
`ifdef TIME_12H_EN
                if (hrT == 4'd1 && hrU == 4'd2) begin
                    hrT <= 4'd0;
                    hrU <= 4'd1;
                end else if (hrU == 4'd9) begin
                    hrT <= 4'd1;
                    hrU <= 4'd0;
                end else begin
                    hrU <= hrU + 4'd1;
                end
`else
                if (hrT == 4'd2 && hrU == 4'd3) begin
                    hrT <= 4'd0;
                    hrU <= 4'd0;
                end else if (hrU == 4'd9) begin
                    hrT <= hrT + 4'd1;
                    hrU <= 4'd0;
                end else begin
                    hrU <= hrU + 4'd1;
                end
`endif
            end
        end
    end

    // Only the HH.MM.SS separators blink; the dot drivers are active-low.
    assign oDOT  = {1'b1, ~dotLit, 1'b1, ~dotLit, 2'b11};
    assign oTICK = tickReg;
    assign oHEX0 = secU;
    assign oHEX1 = secT;
    assign oHEX2 = minU;
    assign oHEX3 = minT;
    assign oHEX4 = hrU;
    assign oHEX5 = hrT;

endmodule
